// File: rtl/cache_sa.sv
// cache_sa: set-associative, write-back, write-allocate data cache with LRU replacement.
// Define CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module cache_sa #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]  t,
                                                  input logic [IDX_W-1:0]  i,
                                                  input logic [OFF_WS-1:0] k);
    line_addr = (ADDR_W'({t, i}) << OFF_W) | ADDR_W'(k);
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q  [WAYS][SETS][LINE_WORDS];
  logic                valid_q [WAYS][SETS];
  logic                valid_d [WAYS][SETS];
  logic                dirty_q [WAYS][SETS];
  logic                dirty_d [WAYS][SETS];
  logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
  logic [TAG_W-1:0]    tag_d   [WAYS][SETS];
  logic                lru_q   [SETS];
  logic                lru_d   [SETS];

  logic                way_q, way_d;
  logic [OFF_WS-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                data_we;
  logic                data_way;
  logic [IDX_W-1:0]    data_idx;
  logic [OFF_WS-1:0]   data_off;
  logic [DATA_W-1:0]   data_wval;

  logic [IDX_W-1:0]    req_idx, cur_idx;
  logic [OFF_WS-1:0]   req_off, cur_off;
  logic [TAG_W-1:0]    req_tag, cur_tag;
  logic                hit, hit_way, victim, found_free, last_word;

  assign req_off = OFF_WS'(cpu_addr & ADDR_W'(LINE_WORDS - 1));
  assign req_idx = IDX_W'(cpu_addr >> OFF_W);
  assign req_tag = TAG_W'(cpu_addr >> (OFF_W + IDX_W));
  assign cur_off = OFF_WS'(addr_q & ADDR_W'(LINE_WORDS - 1));
  assign cur_idx = IDX_W'(addr_q >> OFF_W);
  assign cur_tag = TAG_W'(addr_q >> (OFF_W + IDX_W));
  assign last_word = (word_q == OFF_WS'(LINE_WORDS - 1));

  // Tag compare and victim choice: first invalid way wins, else the LRU way.
  always_comb begin
    hit        = 1'b0;
    hit_way    = 1'b0;
    found_free = 1'b0;
    victim     = (WAYS > 1) ? lru_q[req_idx] : 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
      if (!found_free && !valid_q[w][req_idx]) begin
        found_free = 1'b1;
        victim     = 1'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    lru_d       = lru_q;
    way_d       = way_q;
    word_d      = word_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_hit_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_way    = way_q;
    data_idx    = cur_idx;
    data_off    = word_q;
    data_wval   = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_ack_q) begin
          if (hit) begin
            cpu_ack_d = 1'b1;
            cpu_hit_d = 1'b1;
            if (WAYS > 1) lru_d[req_idx] = ~hit_way;
            if (cpu_we) begin
              data_we                  = 1'b1;
              data_way                 = hit_way;
              data_idx                 = req_idx;
              data_off                 = req_off;
              data_wval                = cpu_wdata;
              dirty_d[hit_way][req_idx] = 1'b1;
              cpu_rdata_d              = cpu_wdata;
            end else begin
              cpu_rdata_d = data_q[hit_way][req_idx][req_off];
            end
          end else begin
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
            way_d   = victim;
            word_d  = '0;
            state_d = (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? WRITEBACK : FILL;
          end
        end
      end

      // Each word raises mem_req for one handshake; the cycle after mem_ack it is low.
      WRITEBACK: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = line_addr(tag_q[way_q][cur_idx], cur_idx, word_q);
          mem_wdata_d = data_q[way_q][cur_idx][word_q];
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (last_word) begin
            word_d                  = '0;
            dirty_d[way_q][cur_idx] = 1'b0;
            state_d                 = FILL;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      FILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(cur_tag, cur_idx, word_q);
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          data_we   = 1'b1;
          if (last_word) begin
            word_d                  = '0;
            valid_d[way_q][cur_idx] = 1'b1;
            dirty_d[way_q][cur_idx] = 1'b0;
            tag_d[way_q][cur_idx]   = cur_tag;
            state_d                 = RESPOND;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      RESPOND: begin
        cpu_ack_d = 1'b1;
        if (WAYS > 1) lru_d[cur_idx] = ~way_q;
        if (we_q) begin
          data_we                 = 1'b1;
          data_off                = cur_off;
          data_wval               = wdata_q;
          dirty_d[way_q][cur_idx] = 1'b1;
          cpu_rdata_d             = wdata_q;
        end else begin
          cpu_rdata_d = data_q[way_q][cur_idx][cur_off];
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      way_q       <= 1'b0;
      word_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
        end
      end
      for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      lru_q       <= lru_d;
    end
  end

  // Line data is plain storage and deliberately survives reset.
  always_ff @(posedge clk_1) begin
    if (data_we) data_q[data_way][data_idx][data_off] <= data_wval;
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits_q, stat_hits_d;
  logic [15:0] stat_misses_q, stat_misses_d;

  // Counters step together with the ack they describe, so they are current when it is seen.
  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (cpu_ack_d && cpu_hit_d && (stat_hits_q != 16'hFFFF))
      stat_hits_d = stat_hits_q + 16'd1;
    if (cpu_ack_d && !cpu_hit_d && (stat_misses_q != 16'hFFFF))
      stat_misses_d = stat_misses_q + 16'd1;
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// tb_cache_sa: randomized scoreboard bench for cache_sa against a recency-list cache model.
// CPU and memory expectations are queued at issue time and checked by independent monitors.
module tb_cache_sa;

  typedef struct packed {
    logic       we;
    logic       hit;
    logic [7:0] rdata;
  } cpu_exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  logic        clk_1, rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_hit;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  int checks = 0;
  int errors = 0;
  int sp_cnt = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Model: per set, resident lines ordered most- to least-recently used.
  logic [13:0] m_la   [16][2];
  logic        m_dirty[16][2];
  logic [7:0]  m_data [16][2][4];
  int          m_cnt  [16];

  cache_sa dut (
    .clk_1(clk_1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 16; s++) m_cnt[s] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic modelAccess(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             output logic hit);
    logic [13:0] la;
    int s, off, pos;
    cpu_exp_t e;
    mem_exp_t m;
    la  = addr[15:2];
    s   = int'(addr[5:2]);
    off = int'(addr[1:0]);
    pos = -1;
    for (int p = 0; p < m_cnt[s]; p++) if (m_la[s][p] == la) pos = p;
    hit = (pos >= 0);
    if (hit) begin
      if (pos == 1) begin
        m_la[s][1] = m_la[s][0];  m_la[s][0] = la;
        {m_dirty[s][0], m_dirty[s][1]} = {m_dirty[s][1], m_dirty[s][0]};
        for (int k = 0; k < 4; k++) {m_data[s][0][k], m_data[s][1][k]} = {m_data[s][1][k], m_data[s][0][k]};
      end
      exp_hits++;
    end else begin
      if (m_cnt[s] == 2 && m_dirty[s][1]) begin
        for (int k = 0; k < 4; k++) begin
          m.we = 1'b1; m.addr = {m_la[s][1], 2'(k)}; m.wdata = m_data[s][1][k];
          mem_q.push_back(m);
        end
      end
      m_la[s][1] = m_la[s][0];
      m_dirty[s][1] = m_dirty[s][0];
      for (int k = 0; k < 4; k++) m_data[s][1][k] = m_data[s][0][k];
      m_la[s][0] = la;
      m_dirty[s][0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_data[s][0][k] = {la[5:0], 2'(k)};
        m.we = 1'b0; m.addr = {la, 2'(k)}; m.wdata = 8'h00;
        mem_q.push_back(m);
      end
      if (m_cnt[s] < 2) m_cnt[s]++;
      exp_misses++;
    end
    if (we) begin
      m_data[s][0][off] = wdata;
      m_dirty[s][0] = 1'b1;
    end
    e.we = we;
    e.hit = hit;
    e.rdata = we ? 8'h00 : m_data[s][0][off];
    cpu_q.push_back(e);
  endtask

  // Called just after a rising edge; returns one idle cycle after the ack.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
    logic hit;
    int cycles;
    modelAccess(we, addr, wdata, hit);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk_1); #1;
      cycles++;
    end while (!cpu_ack && cycles < 300);
    cpu_req = 1'b0;
    if (!cpu_ack) checkOutput("cpu_ack_timeout", 32'd0, 32'd1);
    else if (hit) checkOutput("hit_latency", cycles, 32'd1);
    @(posedge clk_1); #1;
  endtask

  // CPU monitor
  initial begin
    logic prev_ack;
    cpu_exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk_1); #1;
      if (!rst) begin
        prev_ack = 1'b0;
      end else begin
        if (cpu_ack) begin
          checkOutput("ack_not_consecutive", 32'(prev_ack), 32'd0);
          if (cpu_q.size() == 0) begin
            checkOutput("unexpected_cpu_ack", 32'd1, 32'd0);
          end else begin
            e = cpu_q.pop_front();
            checkOutput("cpu_hit", 32'(cpu_hit), 32'(e.hit));
            if (!e.we) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
          end
        end
        prev_ack = cpu_ack;
      end
    end
  end

  // Memory responder and monitor: data = low address byte, ack two cycles after the request.
  initial begin
    int sp_done;
    logic [15:0] a;
    mem_exp_t m;
    sp_done = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk_1);
      if (sp_cnt != sp_done) begin
        sp_done++;
        mem_ack = 1'b1;
        @(negedge clk_1);
        mem_ack = 1'b0;
      end else if (rst && mem_req) begin
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          m = mem_q.pop_front();
          checkOutput("mem_txn", {7'd0, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                      {7'd0, m.we, m.addr, m.wdata});
        end
        a = mem_addr;
        @(negedge clk_1);
        @(negedge clk_1);
        mem_rdata = a[7:0];
        mem_ack = 1'b1;
        @(negedge clk_1);
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic h;
    int acks, found;
    logic [15:0] ra;
    mem_exp_t m;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    modelReset();
    #3 rst = 1'b0;
    repeat (2) @(posedge clk_1);
    #1;
    checkOutput("reset_cpu_ack",   32'(cpu_ack),   32'd0);
    checkOutput("reset_cpu_hit",   32'(cpu_hit),   32'd0);
    checkOutput("reset_mem_req",   32'(mem_req),   32'd0);
    checkOutput("reset_mem_we",    32'(mem_we),    32'd0);
    checkOutput("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("reset_mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk_1) rst = 1'b1;
    @(posedge clk_1); #1;

    // Cold read, then hit in the same line
    applyStimulus(1'b0, 16'h0010, 8'h00);
    applyStimulus(1'b0, 16'h0011, 8'h00);
    // Write hit and read-back
    applyStimulus(1'b1, 16'h0010, 8'h16);
    applyStimulus(1'b0, 16'h0010, 8'h00);

    // Request held for five edges: accepted on edges 1, 3 and 5
    acks = 0;
    repeat (3) modelAccess(1'b0, 16'h0011, 8'h00, h);
    cpu_we = 1'b0; cpu_addr = 16'h0011; cpu_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_1); #1;
      if (cpu_ack) acks++;
    end
    cpu_req = 1'b0;
    checkOutput("hold_ack_count", acks, 32'd3);
    @(posedge clk_1); #1;

    // Dirty eviction in set 4
    applyStimulus(1'b0, 16'h0050, 8'h00);
    applyStimulus(1'b0, 16'h0090, 8'h00);
    applyStimulus(1'b0, 16'h0050, 8'h00);

    // Spurious mem_ack while idle
    sp_cnt++;
    repeat (4) begin @(posedge clk_1); #1; end
    checkOutput("spurious_no_mem_req", 32'(mem_req), 32'd0);
    applyStimulus(1'b0, 16'h0050, 8'h00);

    // Reset during the second fill word of a read of 0x0020
    for (int k = 0; k < 2; k++) begin
      m.we = 1'b0; m.addr = 16'h0020 + 16'(k); m.wdata = 8'h00;
      mem_q.push_back(m);
    end
    cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_req = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk_1);
      if (mem_req && mem_addr == 16'h0021) found = 1;
    end
    checkOutput("reset_fill_reached", found, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midfill_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midfill_cpu_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    modelReset();
    repeat (6) @(negedge clk_1);
    rst = 1'b1;
    @(posedge clk_1); #1;
    applyStimulus(1'b0, 16'h0010, 8'h00);

    // Random traffic over a few conflicting sets and tags, including tag bit 15
    for (int i = 0; i < 200; i++) begin
      ra = 16'(($urandom_range(0, 1) << 15) | ($urandom_range(0, 3) << 6) |
               ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 2) == 0), ra, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_1); #1; end
    end

    repeat (5) begin @(posedge clk_1); #1; end
    checkOutput("cpu_queue_drained", cpu_q.size(), 32'd0);
    checkOutput("mem_queue_drained", mem_q.size(), 32'd0);

`ifdef CACHE_STATS_EN
    checkOutput("stat_hits",   32'(stat_hits),   exp_hits);
    checkOutput("stat_misses", 32'(stat_misses), exp_misses);
    @(negedge clk_1) rst = 1'b0;
    #1;
    checkOutput("stat_hits_reset",   32'(stat_hits),   32'd0);
    checkOutput("stat_misses_reset", 32'(stat_misses), 32'd0);
    @(negedge clk_1) rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised set-associative, write-back, write-allocate data cache. Successor to the single-level direct cache on the CPU bus.
- Sits between the CPU core (request/acknowledge port) and backing memory (word-serial request/acknowledge port).
- Replaces the shared tristate data bus with split read and write data paths.
- Adds associativity, LRU replacement, multi-word lines, dirty-line writeback and miss handling.

Parameters:
- ADDR_W, 16, CPU/memory address width in bits.
- DATA_W, 8, data word width in bits.
- SETS, 16, number of sets; power of two, at least 2.
- WAYS, 2, associativity; 1 or 2.
- LINE_WORDS, 4, words per line; power of two, at least 1.

Ports:
- clk_1  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request valid; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  word address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_hit  out  1  qualifies cpu_ack: 1 = served without memory traffic.
- mem_req  out  1  memory word request; held until mem_ack.
- mem_we  out  1  1 = writeback word, 0 = fill word.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  fill data; valid with mem_ack.
- mem_ack  in  1  memory word complete.

Behaviour:
- Address split: offset = log2(LINE_WORDS) LSBs; index = next log2(SETS) bits; tag = remaining MSBs.
- Per line state: valid bit, dirty bit, tag, LINE_WORDS data words. Per set: one LRU bit (WAYS=2 only).
- Reset (rst low, asynchronous):
  - All valid, dirty and LRU bits cleared; FSM to IDLE.
  - cpu_ack, cpu_hit, mem_req and mem_we are 0; cpu_rdata, mem_addr and mem_wdata are 0.
  - Data arrays are not cleared.
  - Reset mid-fill or mid-writeback aborts the transfer; mem_req drops immediately.
- FSM states: IDLE, WRITEBACK, FILL, RESPOND.
- IDLE:
  - On cpu_req with cpu_ack low, do a combinational tag compare across all ways.
  - Hit: on the next edge, pulse cpu_ack=1 and cpu_hit=1 (latency 1). A read drives the line word to cpu_rdata. A write updates the word and sets dirty. The hit way becomes MRU.
  - Miss: victim is the first invalid way, else the LRU way. Go to WRITEBACK if the victim is valid and dirty, else to FILL.
- WRITEBACK:
  - For LINE_WORDS words k = 0..LINE_WORDS-1: mem_req=1, mem_we=1, mem_addr = {victim tag, index, k}, mem_wdata = word k.
  - Advance k on mem_ack; mem_req drops for at least one cycle between words.
  - After the last word, clear dirty and go to FILL.
- FILL:
  - For k = 0..LINE_WORDS-1: mem_req=1, mem_we=0, mem_addr = {req tag, index, k}.
  - Store mem_rdata on mem_ack.
  - After the last word, set valid, tag and dirty=0, then go to RESPOND.
- RESPOND:
  - Complete the access as a hit would (write merges and sets dirty; read returns the word), but cpu_hit=0.
  - Pulse cpu_ack, update LRU, return to IDLE.
- Handshakes:
  - cpu_ack is never high for two consecutive cycles. A cpu_req still high in the cycle cpu_ack is high is ignored (one access per request assertion edge sequence).
  - mem_ack while mem_req is low is ignored.
- WAYS=1: LRU logic is absent; the victim is always way 0.
- Address bits above the tag are never truncated: tag width = ADDR_W − index bits − offset bits.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds output ports stat_hits and stat_misses, both 16 bits. They increment on each cpu_ack with cpu_hit=1 and cpu_hit=0 respectively, saturate at 0xFFFF, and are cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
All scenarios use defaults: offset = addr[1:0], index = addr[5:2], tag = addr[15:6]. Memory model returns mem_rdata = low byte of mem_addr, with mem_ack 2 cycles after mem_req.
- Cold read: after reset, read 0x0010 → 4 fill requests to 0x0010..0x0013, mem_we=0; cpu_ack with cpu_hit=0, cpu_rdata=0x10. Then read 0x0011 → cpu_ack 1 cycle after request, cpu_hit=1, cpu_rdata=0x11, no mem_req.
- Write hit: write 0x16 to 0x0010 → cpu_ack 1 cycle later, cpu_hit=1. Then read 0x0010 → 0x16, cpu_hit=1, no memory traffic.
- Dirty eviction:
  - After the write above, read 0x0050 (same index 4) → fills way 1.
  - Read 0x0090 → writeback of 0x0010..0x0013 with data 0x16, 0x11, 0x12, 0x13, then fill of 0x0090..0x0093.
  - cpu_rdata=0x90, cpu_hit=0.
  - Read 0x0050 → hit.
- Reset mid-fill: drop rst during the 2nd fill word of a read of 0x0020 → mem_req=0 and cpu_ack=0 immediately. After release, read 0x0010 misses (valid bits cleared).
- Handshake: hold cpu_req high for 5 cycles on a hit to 0x0011 → exactly one cpu_ack pulse per access, never two consecutive high cycles. Assert a spurious mem_ack while idle → no state change.
- CACHE_STATS_EN: run the sequence miss, hit, hit, miss → stat_hits=2, stat_misses=2. After rst, both are 0.
